// File: rtl/freq_gate_bcd_pkg.sv
// Shared definitions for the gated frequency counter: FSM state encoding and BCD limits.
package freq_gate_bcd_pkg;

   typedef enum logic [1:0] {
      S_GATE  = 2'd0,
      S_LATCH = 2'd1,
      S_CLEAR = 2'd2
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/freq_gate_bcd_digit_cnt.sv
// One mod-10 BCD digit of the cascaded edge counter; carry tells the next digit to advance.
module bcd_digit_cnt
   import freq_gate_bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   input  logic       hold,
   output logic [3:0] q,
   output logic       carry
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Clear wins over increment; hold freezes the digit when the whole counter saturates.
   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = 4'd0;
      end else if (inc && !hold) begin
         digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign q     = digit_q;
   assign carry = inc & (digit_q == BCD_MAX);

endmodule

// File: rtl/freq_gate_bcd.sv
// Gated frequency counter core: counts sig_in rising edges over GATE_CYCLES clocks and
// latches the result as packed BCD with a one-cycle valid pulse and a saturation flag.
module freq_gate_bcd
   import freq_gate_bcd_pkg::*;
#(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int DIGITS      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sig_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  valid,
   output logic                  overflow
);

   localparam int              TW         = $clog2(GATE_CYCLES);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(GATE_CYCLES - 1);

   logic                 sync1_q, sync2_q, sync3_q;
   state_e               state_q;
   logic [TW-1:0]        timer_q;
   logic                 ovfSticky_q;
   logic [4*DIGITS-1:0]  bcdOut_q;
   logic                 valid_q;
   logic                 overflow_q;

   logic                 edgeDet;
   logic                 countEn;
   logic                 clrCount;
   logic                 saturate;
   logic [DIGITS:0]      incChain;
   logic [4*DIGITS-1:0]  counter;

   // Two flops resolve metastability on the asynchronous input; the third gives the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign edgeDet     = sync2_q & ~sync3_q;
   assign countEn     = edgeDet & (state_q == S_GATE);
   assign clrCount    = (state_q == S_CLEAR);
   assign incChain[0] = countEn;

   // A carry out of the top digit means every digit is 9, so the counter freezes there.
   assign saturate = incChain[DIGITS];

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit_cnt u_digit (
         .clk   (clk),
         .rst   (rst),
         .clr   (clrCount),
         .inc   (incChain[k]),
         .hold  (saturate),
         .q     (counter[4*k +: 4]),
         .carry (incChain[k+1])
      );
   end

   // Gate window, then one cycle to latch the result and one to clear for the next window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_GATE;
         timer_q     <= '0;
         ovfSticky_q <= 1'b0;
         bcdOut_q    <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_GATE: begin
               timer_q <= timer_q + TW'(1);
               if (saturate) begin
                  ovfSticky_q <= 1'b1;
               end
               if (timer_q == TIMER_LAST) begin
                  state_q <= S_LATCH;
               end
            end
            S_LATCH: begin
               bcdOut_q   <= counter;
               overflow_q <= ovfSticky_q;
               valid_q    <= 1'b1;
               state_q    <= S_CLEAR;
            end
            S_CLEAR: begin
               timer_q     <= '0;
               ovfSticky_q <= 1'b0;
               state_q     <= S_GATE;
            end
            default: begin
               timer_q     <= '0;
               ovfSticky_q <= 1'b0;
               state_q     <= S_GATE;
            end
         endcase
      end
   end

   assign bcd_out  = bcdOut_q;
   assign valid    = valid_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_gate_bcd.sv
// Directed bench for freq_gate_bcd: a 100-cycle gate instance for most cases and a
// 300-cycle gate instance for the saturation case, sharing clock and reset.
module tb_freq_gate_bcd;

   logic       clk = 1'b0;
   logic       rst;
   logic       sigA, sigB;
   logic [7:0] bcdA, bcdB;
   logic       validA, validB;
   logic       ovfA, ovfB;

   int   total = 0;
   int   bad   = 0;
   int   tick  = 0;
   int   modeA = 0;
   int   modeB = 0;
   logic pulseA = 1'b0;
   int   n;

   always #5 clk = ~clk;

   freq_gate_bcd #(.GATE_CYCLES(100), .DIGITS(2)) dutA (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sigA),
      .bcd_out  (bcdA),
      .valid    (validA),
      .overflow (ovfA)
   );

   freq_gate_bcd #(.GATE_CYCLES(300), .DIGITS(2)) dutB (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sigB),
      .bcd_out  (bcdB),
      .valid    (validB),
      .overflow (ovfB)
   );

   // Mode 1 is a period-4 square wave, mode 2 period-2, anything else follows the manual level.
   function automatic logic waveLevel(input int mode, input int t, input logic manual);
      case (mode)
         1:       return t[1];
         2:       return t[0];
         default: return manual;
      endcase
   endfunction

   task automatic applyStimulus();
      @(negedge clk);
      tick++;
      sigA = waveLevel(modeA, tick, pulseA);
      sigB = waveLevel(modeB, tick, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Steps until the selected instance shows valid; n is the number of negedges taken.
   task automatic waitValid(input bit useB, input int bound, output int cnt);
      bit found;
      found = 1'b0;
      cnt   = 0;
      while (!found && cnt < bound) begin
         applyStimulus();
         cnt++;
         found = useB ? validB : validA;
      end
      checkOutput(useB ? "validB seen" : "validA seen", 32'(found), 32'd1);
   endtask

   // Raises sigA at the k-th following negedge for exactly one cycle.
   task automatic pulseAt(input int k);
      repeat (k - 1) applyStimulus();
      pulseA = 1'b1;
      applyStimulus();
      pulseA = 1'b0;
      applyStimulus();
   endtask

   initial begin
      rst  = 1'b0;
      sigA = 1'b0;
      sigB = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("reset bcdA", 32'(bcdA), 32'h00);
      checkOutput("reset validA", 32'(validA), 32'd0);
      checkOutput("reset ovfA", 32'(ovfA), 32'd0);
      checkOutput("reset validB", 32'(validB), 32'd0);
      repeat (2) applyStimulus();
      rst = 1'b1;

      $display("[TB] idle input");
      waitValid(1'b0, 200, n);
      checkOutput("t1 first latency", 32'(n), 32'd101);
      checkOutput("t1 bcd", 32'(bcdA), 32'h00);
      checkOutput("t1 ovf", 32'(ovfA), 32'd0);
      waitValid(1'b0, 200, n);
      checkOutput("t1 period", 32'(n), 32'd102);
      checkOutput("t1 bcd again", 32'(bcdA), 32'h00);
      applyStimulus();
      checkOutput("t1 valid one cycle", 32'(validA), 32'd0);

      $display("[TB] period-4 input");
      modeA = 1;
      waitValid(1'b0, 200, n);
      waitValid(1'b0, 200, n);
      checkOutput("t2 period", 32'(n), 32'd102);
      checkOutput("t2 bcd", 32'(bcdA), 32'h25);
      checkOutput("t2 ovf", 32'(ovfA), 32'd0);

      $display("[TB] period-2 input");
      modeA = 2;
      waitValid(1'b0, 200, n);
      waitValid(1'b0, 200, n);
      checkOutput("t3 bcd", 32'(bcdA), 32'h50);
      checkOutput("t3 ovf", 32'(ovfA), 32'd0);

      $display("[TB] isolated pulses");
      modeA = 0;
      waitValid(1'b0, 200, n);
      waitValid(1'b0, 200, n);
      pulseAt(99);
      waitValid(1'b0, 200, n);
      checkOutput("t5 before latch edge", 32'(bcdA), 32'h00);
      pulseAt(100);
      waitValid(1'b0, 200, n);
      checkOutput("t5 latch edge dropped", 32'(bcdA), 32'h00);
      waitValid(1'b0, 200, n);
      checkOutput("t5 clear edge dropped", 32'(bcdA), 32'h00);
      pulseAt(98);
      waitValid(1'b0, 200, n);
      checkOutput("t5 last gate edge", 32'(bcdA), 32'h01);
      waitValid(1'b0, 200, n);
      checkOutput("t5 quiet after", 32'(bcdA), 32'h00);

      $display("[TB] saturation");
      modeB = 2;
      waitValid(1'b1, 400, n);
      waitValid(1'b1, 400, n);
      checkOutput("t4 period", 32'(n), 32'd302);
      checkOutput("t4 bcd", 32'(bcdB), 32'h99);
      checkOutput("t4 ovf", 32'(ovfB), 32'd1);
      modeB = 0;
      waitValid(1'b1, 400, n);
      checkOutput("t4 ovf cleared", 32'(ovfB), 32'd0);
      waitValid(1'b1, 400, n);
      checkOutput("t4 bcd idle", 32'(bcdB), 32'h00);
      checkOutput("t4 ovf idle", 32'(ovfB), 32'd0);

      $display("[TB] mid-window reset");
      modeA = 1;
      waitValid(1'b0, 200, n);
      waitValid(1'b0, 200, n);
      checkOutput("t6 pre-reset bcd", 32'(bcdA), 32'h25);
      repeat (50) applyStimulus();
      rst = 1'b0;
      #1;
      checkOutput("t6 async bcd", 32'(bcdA), 32'h00);
      checkOutput("t6 async valid", 32'(validA), 32'd0);
      checkOutput("t6 async ovf", 32'(ovfA), 32'd0);
      repeat (3) applyStimulus();
      tick = 0;
      applyStimulus();
      rst = 1'b1;
      waitValid(1'b0, 200, n);
      checkOutput("t6 latency", 32'(n), 32'd101);
      checkOutput("t6 bcd full", 32'(bcdA), 32'h25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
